// File: rtl/rysy_alu.sv
// -----------------------------------------------------------------------------
// rysy_alu
// Integer ALU of the Rysy RV32I execute stage. Computes one of ten RV32I
// arithmetic/logic/shift/compare operations on two REG_LEN-bit operands and
// captures the result into a single output register every clock cycle.
//
// Ports
//   clk      in   1        core clock, rising-edge active
//   rst_n    in   1        asynchronous active-low reset, clears alu_out
//   alu_in1  in   REG_LEN  operand A (rs1 or PC)
//   alu_in2  in   REG_LEN  operand B (rs2 or immediate), low bits give shamt
//   alu_op   in   4        operation select (10..15 reserved -> zero result)
//   alu_out  out  REG_LEN  registered result, one cycle latency
//
// REG_LEN must be a power of two and at least 8 so that the shift amount
// field alu_in2[$clog2(REG_LEN)-1:0] covers exactly the legal shift range.
// -----------------------------------------------------------------------------
module rysy_alu #(
  parameter int REG_LEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REG_LEN-1:0] alu_in1,
  input  logic [REG_LEN-1:0] alu_in2,
  input  logic [3:0]         alu_op,
  output logic [REG_LEN-1:0] alu_out
);

  localparam int SHAMT_W = $clog2(REG_LEN);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } alu_op_e;

  // Zero-extend a single compare flag to the full result width.
  function automatic logic [REG_LEN-1:0] flag_ext(input logic flag);
    flag_ext = {{(REG_LEN-1){1'b0}}, flag};
  endfunction

  // Signed less-than expressed on raw vectors: differing signs decide
  // directly, equal signs fall back to the unsigned order of the vectors.
  function automatic logic signed_lt(input logic [REG_LEN-1:0] a,
                                     input logic [REG_LEN-1:0] b);
    if (a[REG_LEN-1] != b[REG_LEN-1]) begin
      signed_lt = a[REG_LEN-1];
    end else begin
      signed_lt = (a < b);
    end
  endfunction

  logic [SHAMT_W-1:0] shamt_s;
  logic [REG_LEN-1:0] sum_s;
  logic [REG_LEN-1:0] diff_s;
  logic [REG_LEN-1:0] sll_s;
  logic [REG_LEN-1:0] srl_s;
  logic [REG_LEN-1:0] sra_s;
  logic               lt_s;
  logic               ltu_s;
  logic [REG_LEN-1:0] result_s;
  logic [REG_LEN-1:0] alu_out_r;

  // Upper bits of operand B never influence a shift.
  assign shamt_s = alu_in2[SHAMT_W-1:0];

  // Datapath units, all evaluated in parallel; the op mux picks one.
  always_comb begin
    sum_s  = alu_in1 + alu_in2;
    diff_s = alu_in1 - alu_in2;
    sll_s  = alu_in1 << shamt_s;
    srl_s  = alu_in1 >> shamt_s;
    sra_s  = REG_LEN'($signed(alu_in1) >>> shamt_s);
    lt_s   = signed_lt(alu_in1, alu_in2);
    ltu_s  = (alu_in1 < alu_in2);
  end

  // Result select; reserved and unknown opcodes yield zero.
  always_comb begin
    result_s = {REG_LEN{1'b0}};
    case (alu_op)
      OP_ADD:  result_s = sum_s;
      OP_SUB:  result_s = diff_s;
      OP_AND:  result_s = alu_in1 & alu_in2;
      OP_OR:   result_s = alu_in1 | alu_in2;
      OP_XOR:  result_s = alu_in1 ^ alu_in2;
      OP_SLL:  result_s = sll_s;
      OP_SRL:  result_s = srl_s;
      OP_SRA:  result_s = sra_s;
      OP_SLT:  result_s = flag_ext(lt_s);
      OP_SLTU: result_s = flag_ext(ltu_s);
      default: result_s = {REG_LEN{1'b0}};
    endcase
  end

  // Output register: reset clears it immediately, otherwise it takes a fresh
  // result every edge, so an in-flight result is simply dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_r <= {REG_LEN{1'b0}};
    end else begin
      alu_out_r <= result_s;
    end
  end

  assign alu_out = alu_out_r;

endmodule

// File: tb/tb_rysy_alu.sv
// -----------------------------------------------------------------------------
// tb_rysy_alu
// Self-checking bench for rysy_alu (REG_LEN = 32). Inputs are driven on the
// falling edge; the expected result is pushed to a scoreboard queue at the
// same time and popped/compared on the next falling edge, after the DUT has
// captured it on the intervening rising edge.
// -----------------------------------------------------------------------------
module tb_rysy_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;

  int n_checks;
  int n_pass;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  rysy_alu #(.REG_LEN(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .alu_in1 (alu_in1),
    .alu_in2 (alu_in2),
    .alu_op  (alu_op),
    .alu_out (alu_out)
  );

  // 10 ns core clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Independent reference: bitwise loops and explicit sign reasoning.
  function automatic logic [31:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    int          sh;
    sh = int'(b & 32'h0000_001F);
    r  = a;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a + ~b + 32'd1;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0};
      4'd6: for (int i = 0; i < sh; i++) r = {1'b0, r[31:1]};
      4'd7: for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
      4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Compare the oldest outstanding result, if any.
  task automatic drain_one();
    logic [31:0] e;
    string       t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, alu_out, e);
    end
  endtask

  // On a falling edge: retire the previous result, then apply a new op.
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input string tag);
    @(negedge clk);
    drain_one();
    alu_op  = op;
    alu_in1 = a;
    alu_in2 = b;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic flush();
    @(negedge clk);
    drain_one();
  endtask

  logic [31:0] pa [5];
  logic [31:0] pb [5];
  logic [31:0] add_exp [5];
  logic [31:0] sub_exp [5];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    alu_in1  = 32'd0;
    alu_in2  = 32'd0;
    alu_op   = 4'd0;

    pa = '{32'd10, 32'd3, 32'hFFFF_FFFC, 32'd4, 32'hFFFF_FFF0};
    pb = '{32'd2, 32'd10, 32'd4, 32'hFFFF_FFFC, 32'd2};
    add_exp = '{32'd12, 32'd13, 32'd0, 32'd0, 32'hFFFF_FFF2};
    sub_exp = '{32'd8, 32'hFFFF_FFF9, 32'hFFFF_FFF8, 32'd8, 32'hFFFF_FFEE};

    // Reset state while held low across edges.
    repeat (2) @(posedge clk);
    #1 check("reset_hold", alu_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Arithmetic on the operand pairs.
    for (int i = 0; i < 5; i++) issue(4'd0, pa[i], pb[i], add_exp[i], $sformatf("add%0d", i));
    for (int i = 0; i < 5; i++) issue(4'd1, pa[i], pb[i], sub_exp[i], $sformatf("sub%0d", i));
    issue(4'd2, 32'hFFFF_FFFC, 32'd4, 32'd4, "and");
    issue(4'd3, 32'd10, 32'd2, 32'd10, "or");
    issue(4'd4, 32'd10, 32'd2, 32'd8, "xor");

    // Shifts, including zero shamt and ignored upper bits.
    issue(4'd5, 32'd10, 32'd2, 32'd40, "sll");
    issue(4'd6, 32'hFFFF_FFF0, 32'd2, 32'h3FFF_FFFC, "srl");
    issue(4'd7, 32'hFFFF_FFF0, 32'd2, 32'hFFFF_FFFC, "sra");
    issue(4'd7, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, "sra31");
    issue(4'd5, 32'd1, 32'h0000_0025, 32'h0000_0020, "sll_hi_bits");
    issue(4'd5, 32'hA5A5_0F0F, 32'hFFFF_FFE0, 32'hA5A5_0F0F, "sll_sh0");
    issue(4'd6, 32'hA5A5_0F0F, 32'h0000_0000, 32'hA5A5_0F0F, "srl_sh0");
    issue(4'd7, 32'h8000_0001, 32'h0000_0020, 32'h8000_0001, "sra_sh0");

    // Compares.
    issue(4'd8, 32'd3, 32'd10, 32'd1, "slt_a");
    issue(4'd8, 32'hFFFF_FFFC, 32'd4, 32'd1, "slt_b");
    issue(4'd8, 32'd4, 32'hFFFF_FFFC, 32'd0, "slt_c");
    issue(4'd8, 32'd10, 32'd10, 32'd0, "slt_eq");
    issue(4'd9, 32'hFFFF_FFFC, 32'd4, 32'd0, "sltu_a");
    issue(4'd9, 32'd4, 32'hFFFF_FFFC, 32'd1, "sltu_b");
    issue(4'd9, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd0, "sltu_eq");

    // Wrap-around.
    issue(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, "add_wrap");
    issue(4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, "sub_wrap");

    // Back-to-back sweep over every opcode with fixed operands.
    for (int op = 0; op < 16; op++) begin
      issue(4'(op), 32'h8000_00F3, 32'h0000_0025,
            model(4'(op), 32'h8000_00F3, 32'h0000_0025), $sformatf("sweep_op%0d", op));
    end
    for (int op = 15; op >= 0; op--) begin
      issue(4'(op), 32'h1234_5678, 32'hFEDC_BA98,
            model(4'(op), 32'h1234_5678, 32'hFEDC_BA98), $sformatf("sweep2_op%0d", op));
    end
    flush();

    // Mid-cycle reset with a nonzero result on the output.
    issue(4'd0, 32'd10, 32'd2, 32'd12, "pre_reset");
    flush();
    #2 rst_n = 1'b0;
    #1 check("reset_async", alu_out, 32'd0);

    // Reset over an edge with an op applied: the in-flight result is dropped.
    alu_op  = 4'd4;
    alu_in1 = 32'd10;
    alu_in2 = 32'd2;
    @(posedge clk);
    #1 check("reset_discard", alu_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_release", alu_out, 32'd0);
    @(posedge clk);
    #1 check("first_after_reset", alu_out, 32'd8);

    issue(4'd1, 32'd3, 32'd10, 32'hFFFF_FFF9, "post_reset_sub");
    flush();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
